tl_ul_ram_responder: RTL
========================

// Module: tl_ul_ram_responder
// PURPOSE
//  TileLink-UL manager (responder) terminating one 32-bit A/D channel pair from the fabric.
//  Accepts Get / PutFullData / PutPartialData on channel A. Services them from a local word RAM.
//  Returns AccessAck / AccessAckData on channel D. Sits at the slave end of the TL crossbar links.
// PARAMETERS
//  DEPTH_LOG2   8            log2 of RAM depth in 32-bit words
//  BASE_ADDR    30'h0000000  base of decoded window; aligned to 4<<DEPTH_LOG2
// PORTS
//  clock        in   1   sole clock; all state updates on rising edge
//  reset        in   1   synchronous, active-high
//  a_valid      in   1   A beat valid
//  a_ready      out  1   A beat accepted when a_valid&a_ready (A fire)
//  a_opcode     in   3   0 PutFull, 1 PutPartial, 4 Get; all others unsupported
//  a_param      in   3   ignored
//  a_size       in   4   log2 bytes; legal 0..2
//  a_source     in   7   requester tag, echoed on D
//  a_address    in   30  byte address
//  a_mask       in   4   byte lanes to write
//  a_data       in   32  write data
//  a_corrupt    in   1   write data poisoned
//  d_valid      out  1   response valid
//  d_ready      in   1   response consumed when d_valid&d_ready (D fire)
//  d_opcode     out  3   0 AccessAck, 1 AccessAckData
//  d_param      out  2   constant 0
//  d_size       out  4   echo of a_size
//  d_source     out  7   echo of a_source
//  d_sink       out  1   constant 0
//  d_denied     out  1   request refused
//  d_data       out  32  read data; 0 unless AccessAckData and not denied
//  d_corrupt    out  1   1 for denied AccessAckData, else 0
//  err_count    out  16  saturating count of denied responses issued
// BEHAVIOUR
//  - One-entry response register (RSP). a_ready = ~d_valid | d_ready, so back-to-back fires occur at one per cycle.
//  - A fire in cycle N loads RSP. d_valid is high in N+1 and holds, with all D fields stable, until D fire.
//  - D fire without A fire clears d_valid. A fire and D fire in the same cycle replace RSP and keep d_valid=1.
//  - Decode:
//    - in_range = a_address[29:DEPTH_LOG2+2] == BASE_ADDR[29:DEPTH_LOG2+2].
//    - aligned = a_address low a_size bits are zero.
//    - legal = in_range & aligned & a_size<=2.
//  - Get (4): d_opcode=1.
//    - If legal: d_data = RAM[a_address[DEPTH_LOG2+1:2]] as read at the fire edge; denied=0; corrupt=0.
//    - Else: denied=1, corrupt=1, d_data=0.
//  - PutFull (0) / PutPartial (1): d_opcode=0.
//    - If legal & ~a_corrupt: write the RAM byte lanes selected by a_mask at the fire edge; denied=0.
//    - Else: no write; denied=1.
//  - Unsupported opcode: d_opcode=0, denied=1, no RAM access.
//  - Read-after-write: a Put fired in cycle N is visible to a Get fired in cycle N+1. No bypass is needed within a single cycle.
//  - Mask is applied as given. PutFull with a partial mask still writes only the masked lanes.
//  - a_mask==0 on a legal Put: no write; AccessAck with denied=0.
//  - err_count increments by 1 on each A fire whose response is denied. It saturates at 16'hFFFF and does not wrap.
//  - Reset:
//    - d_valid=0, a_ready=1; all D fields 0; err_count=0.
//    - A response pending at reset is dropped.
//    - RAM contents are not reset and are undefined until written.
//  - No combinational path from any A input to any D output. a_ready depends only on d_valid and d_ready.
// TESTING
//  - Reset: assert reset 2 cycles -> d_valid=0, a_ready=1, err_count=0.
//  - Write/read:
//    - Stimulus: PutFull addr=BASE+0x10, mask=F, data=DEADBEEF, src=5; then Get same addr, size=2, src=6, d_ready=1.
//    - Required: AccessAck src=5 denied=0; then AccessAckData src=6 data=DEADBEEF. Each response 1 cycle after its fire.
//  - Partial write:
//    - Stimulus: PutPartial mask=4'b0010, data=0000AA00 over DEADBEEF; then Get.
//    - Required: read data=DEADAAEF.
//  - Backpressure:
//    - Stimulus: hold d_ready=0 for 5 cycles with a_valid=1.
//    - Required: a_ready=0 while d_valid=1, D fields stable, exactly 1 response queued. With d_ready=1 thereafter: 1 fire per cycle.
//  - Denials:
//    - Stimulus: Get at BASE+(4<<DEPTH_LOG2); Get addr=BASE+2 size=2; opcode=2; Put with a_corrupt=1.
//    - Required: all four denied=1; Get responses have corrupt=1, data=0; RAM unchanged; err_count=4.
//  - Reset mid-operation:
//    - Stimulus: assert reset while d_valid=1, d_ready=0.
//    - Required: d_valid=0 the next cycle; the stale response is never delivered.

Source files
------------

// File: rtl/tl_ul_ram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tl_ul_ram_responder                                          |
// | Description : TileLink-UL manager terminating one 32-bit A/D channel pair. |
// |               Services Get / PutFullData / PutPartialData from a local     |
// |               word RAM and answers through a one-entry D response register.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tl_ul_ram_responder #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter logic [29:0] BASE_ADDR  = 30'h0000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [2:0]  a_opcode,
  input  logic [2:0]  a_param,
  input  logic [3:0]  a_size,
  input  logic [6:0]  a_source,
  input  logic [29:0] a_address,
  input  logic [3:0]  a_mask,
  input  logic [31:0] a_data,
  input  logic        a_corrupt,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [2:0]  d_opcode,
  output logic [1:0]  d_param,
  output logic [3:0]  d_size,
  output logic [6:0]  d_source,
  output logic        d_sink,
  output logic        d_denied,
  output logic [31:0] d_data,
  output logic        d_corrupt,
  output logic [15:0] err_count
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned IDX_MSB = DEPTH_LOG2 + 1;
  localparam int unsigned TAG_LSB = DEPTH_LOG2 + 2;

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

  // Word storage; intentionally never reset.
  logic [31:0] mem [DEPTH];

  logic                  a_fire;
  logic                  in_range;
  logic                  aligned;
  logic                  legal;
  logic                  is_get;
  logic                  is_put;
  logic                  do_write;
  logic                  rsp_denied;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  unused_param;

  // a_param carries no meaning for this manager.
  assign unused_param = ^a_param;

  // Ready depends only on the response register, never on A inputs.
  assign a_ready = ~d_valid | d_ready;
  assign a_fire  = a_valid & a_ready;

  assign idx      = a_address[IDX_MSB:2];
  assign in_range = (a_address[29:TAG_LSB] == BASE_ADDR[29:TAG_LSB]);
  assign is_get   = (a_opcode == OP_GET);
  assign is_put   = (a_opcode == OP_PUT_FULL) | (a_opcode == OP_PUT_PARTIAL);

  // Natural alignment: the low a_size address bits must be zero.
  always_comb begin
    aligned = 1'b0;
    case (a_size)
      4'd0:    aligned = 1'b1;
      4'd1:    aligned = ~a_address[0];
      4'd2:    aligned = (a_address[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign legal = in_range & aligned & (a_size <= 4'd2);

  // Puts are refused when illegal or poisoned; unsupported opcodes always are.
  always_comb begin
    rsp_denied = 1'b1;
    if (is_get) begin
      rsp_denied = ~legal;
    end else if (is_put) begin
      rsp_denied = ~legal | a_corrupt;
    end
  end

  // A zero mask on a legal Put is accepted but touches no lanes.
  assign do_write = a_fire & is_put & ~rsp_denied & ~reset;

  // Byte-lane RAM write at the A fire edge.
  always_ff @(posedge clock) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (a_mask[b]) begin
          mem[idx][8*b +: 8] <= a_data[8*b +: 8];
        end
      end
    end
  end

  // One-entry response register; A fire reloads it, D fire alone empties it.
  always_ff @(posedge clock) begin
    if (reset) begin
      d_valid   <= 1'b0;
      d_opcode  <= 3'd0;
      d_size    <= 4'd0;
      d_source  <= 7'd0;
      d_denied  <= 1'b0;
      d_data    <= 32'd0;
      d_corrupt <= 1'b0;
    end else if (a_fire) begin
      d_valid   <= 1'b1;
      d_opcode  <= is_get ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
      d_size    <= a_size;
      d_source  <= a_source;
      d_denied  <= rsp_denied;
      d_data    <= (is_get && !rsp_denied) ? mem[idx] : 32'd0;
      d_corrupt <= is_get & rsp_denied;
    end else if (d_ready) begin
      d_valid   <= 1'b0;
    end
  end

  // Saturating count of denied responses issued.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_count <= 16'd0;
    end else if (a_fire && rsp_denied && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end

  assign d_param = 2'd0;
  assign d_sink  = 1'b0;

endmodule
`default_nettype wire
